// File: rtl/operand_fetch_if.sv
// Operand-fetch bus bundle: decode-side request, register-file read port,
// writeback snoop, execute-side output slot and stall statistics.
interface operand_fetch_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  id_valid_i;
   logic                  id_ready_o;
   logic [ADDR_WIDTH-1:0] rs1_i;
   logic [ADDR_WIDTH-1:0] rs2_i;
   logic [ADDR_WIDTH-1:0] rd_i;
   logic                  rd_we_i;
   logic [ADDR_WIDTH-1:0] raddr_a_o;
   logic [ADDR_WIDTH-1:0] raddr_b_o;
   logic [DATA_WIDTH-1:0] rdata_a_i;
   logic [DATA_WIDTH-1:0] rdata_b_i;
   logic                  wb_valid_i;
   logic [ADDR_WIDTH-1:0] wb_addr_i;
   logic [DATA_WIDTH-1:0] wb_data_i;
   logic                  flush_i;
   logic                  ex_valid_o;
   logic                  ex_ready_i;
   logic [DATA_WIDTH-1:0] ex_op_a_o;
   logic [DATA_WIDTH-1:0] ex_op_b_o;
   logic [ADDR_WIDTH-1:0] ex_rd_o;
   logic                  ex_rd_we_o;
   logic [15:0]           stall_cnt_o;

   modport slave (
      input  id_valid_i, rs1_i, rs2_i, rd_i, rd_we_i,
      input  rdata_a_i, rdata_b_i,
      input  wb_valid_i, wb_addr_i, wb_data_i,
      input  flush_i, ex_ready_i,
      output id_ready_o, raddr_a_o, raddr_b_o,
      output ex_valid_o, ex_op_a_o, ex_op_b_o, ex_rd_o, ex_rd_we_o,
      output stall_cnt_o
   );

   modport master (
      output id_valid_i, rs1_i, rs2_i, rd_i, rd_we_i,
      output rdata_a_i, rdata_b_i,
      output wb_valid_i, wb_addr_i, wb_data_i,
      output flush_i, ex_ready_i,
      input  id_ready_o, raddr_a_o, raddr_b_o,
      input  ex_valid_o, ex_op_a_o, ex_op_b_o, ex_rd_o, ex_rd_we_o,
      input  stall_cnt_o
   );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboard hazard check, register-file read, output slot.
// Optional macro OPFETCH_BYPASS_EN forwards same-cycle writeback data to sources.
module operand_fetch #(
   parameter int unsigned REG_COUNT  = 32,
   parameter int unsigned ADDR_WIDTH = $clog2(REG_COUNT),
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic           clk,
   input logic           rst_n,
   operand_fetch_if.slave bus
);
   localparam int unsigned CNT_WIDTH = 16;

`ifdef OPFETCH_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [REG_COUNT-1:0]  busy;
   logic [REG_COUNT-1:0]  busy_nxt;
   logic                  rs1_nz;
   logic                  rs2_nz;
   logic                  rd_nz;
   logic                  byp_a;
   logic                  byp_b;
   logic                  hazard;
   logic                  issue;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;

   assign bus.raddr_a_o = bus.rs1_i;
   assign bus.raddr_b_o = bus.rs2_i;

   assign rs1_nz = (bus.rs1_i != ADDR_WIDTH'(0));
   assign rs2_nz = (bus.rs2_i != ADDR_WIDTH'(0));
   assign rd_nz  = (bus.rd_i  != ADDR_WIDTH'(0));

   // A writeback landing this edge can satisfy a waiting source only when forwarding exists
   assign byp_a = BYPASS && bus.wb_valid_i && rs1_nz && (bus.wb_addr_i == bus.rs1_i);
   assign byp_b = BYPASS && bus.wb_valid_i && rs2_nz && (bus.wb_addr_i == bus.rs2_i);

   assign hazard = (rs1_nz && busy[bus.rs1_i] && !byp_a) ||
                   (rs2_nz && busy[bus.rs2_i] && !byp_b) ||
                   (bus.rd_we_i && rd_nz && busy[bus.rd_i]);

   assign bus.id_ready_o = !hazard && (!bus.ex_valid_o || bus.ex_ready_i) && !bus.flush_i;
   assign issue          = bus.id_valid_i && bus.id_ready_o;

   assign op_a = !rs1_nz ? DATA_WIDTH'(0) : (byp_a ? bus.wb_data_i : bus.rdata_a_i);
   assign op_b = !rs2_nz ? DATA_WIDTH'(0) : (byp_b ? bus.wb_data_i : bus.rdata_b_i);

   // Clears first so that a same-cycle set on the same register wins
   always_comb begin
      busy_nxt = busy;
      if (bus.wb_valid_i && (bus.wb_addr_i != ADDR_WIDTH'(0)))
         busy_nxt[bus.wb_addr_i] = 1'b0;
      if (bus.flush_i && bus.ex_valid_o && bus.ex_rd_we_o)
         busy_nxt[bus.ex_rd_o] = 1'b0;
      if (issue && bus.rd_we_i && rd_nz)
         busy_nxt[bus.rd_i] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Output slot: flush kills, issue loads, handshake without issue empties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ex_valid_o <= 1'b0;
         bus.ex_op_a_o  <= '0;
         bus.ex_op_b_o  <= '0;
         bus.ex_rd_o    <= '0;
         bus.ex_rd_we_o <= 1'b0;
      end else if (bus.flush_i) begin
         bus.ex_valid_o <= 1'b0;
      end else if (issue) begin
         bus.ex_valid_o <= 1'b1;
         bus.ex_op_a_o  <= op_a;
         bus.ex_op_b_o  <= op_b;
         bus.ex_rd_o    <= bus.rd_i;
         bus.ex_rd_we_o <= bus.rd_we_i && rd_nz;
      end else if (bus.ex_ready_i) begin
         bus.ex_valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.stall_cnt_o <= '0;
      end else if (bus.id_valid_i && hazard && (bus.stall_cnt_o != {CNT_WIDTH{1'b1}})) begin
         bus.stall_cnt_o <= bus.stall_cnt_o + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: issue, forwarding/stall, backpressure,
// x0 handling, flush, hazard counting and mid-handshake reset.
module tb_operand_fetch;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   exp_stall;

   operand_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   operand_fetch #(.REG_COUNT(32), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_valid_i = 1'b0;
      bus.rs1_i      = '0;
      bus.rs2_i      = '0;
      bus.rd_i       = '0;
      bus.rd_we_i    = 1'b0;
      bus.rdata_a_i  = '0;
      bus.rdata_b_i  = '0;
      bus.wb_valid_i = 1'b0;
      bus.wb_addr_i  = '0;
      bus.wb_data_i  = '0;
      bus.flush_i    = 1'b0;
      bus.ex_ready_i = 1'b1;
   endtask

   task automatic present(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic we,
                          input logic [DW-1:0] da, input logic [DW-1:0] db);
      bus.id_valid_i = 1'b1;
      bus.rs1_i      = rs1;
      bus.rs2_i      = rs2;
      bus.rd_i       = rd;
      bus.rd_we_i    = we;
      bus.rdata_a_i  = da;
      bus.rdata_b_i  = db;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      bus.rs1_i = 5'd9;
      bus.rs2_i = 5'd17;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid: got %0b expected 0", bus.ex_valid_o); end
      n_cmp++; if (bus.ex_op_a_o !== 32'h0 || bus.ex_op_b_o !== 32'h0) begin n_err++; $display("FAIL reset_ops: got %h/%h expected 0/0", bus.ex_op_a_o, bus.ex_op_b_o); end
      n_cmp++; if (bus.ex_rd_o !== 5'd0 || bus.ex_rd_we_o !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %0d/%0b expected 0/0", bus.ex_rd_o, bus.ex_rd_we_o); end
      n_cmp++; if (bus.stall_cnt_o !== 16'h0) begin n_err++; $display("FAIL reset_stall_cnt: got %h expected 0", bus.stall_cnt_o); end
      n_cmp++; if (dut.busy !== 32'h0) begin n_err++; $display("FAIL reset_busy: got %h expected 0", dut.busy); end
      n_cmp++; if (bus.raddr_a_o !== 5'd9 || bus.raddr_b_o !== 5'd17) begin n_err++; $display("FAIL raddr_passthru: got %0d/%0d expected 9/17", bus.raddr_a_o, bus.raddr_b_o); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_issue();
      idle();
      present(5'd1, 5'd2, 5'd3, 1'b1, 32'd5, 32'd7);
      #1;
      n_cmp++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL basic_id_ready: got %0b expected 1", bus.id_ready_o); end
      tick();
      bus.id_valid_i = 1'b0;
      n_cmp++; if (bus.ex_valid_o !== 1'b1) begin n_err++; $display("FAIL basic_ex_valid: got %0b expected 1", bus.ex_valid_o); end
      n_cmp++; if (bus.ex_op_a_o !== 32'd5 || bus.ex_op_b_o !== 32'd7) begin n_err++; $display("FAIL basic_ops: got %h/%h expected 5/7", bus.ex_op_a_o, bus.ex_op_b_o); end
      n_cmp++; if (bus.ex_rd_o !== 5'd3 || bus.ex_rd_we_o !== 1'b1) begin n_err++; $display("FAIL basic_rd: got %0d/%0b expected 3/1", bus.ex_rd_o, bus.ex_rd_we_o); end
      n_cmp++; if (dut.busy[3] !== 1'b1) begin n_err++; $display("FAIL basic_busy3: got %0b expected 1", dut.busy[3]); end
      tick();
      n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %0b expected 0", bus.ex_valid_o); end
   endtask

   task automatic test_bypass();
      idle();
      present(5'd3, 5'd0, 5'd6, 1'b1, 32'hDEAD, 32'h99);
      bus.wb_valid_i = 1'b1;
      bus.wb_addr_i  = 5'd3;
      bus.wb_data_i  = 32'h12;
      #1;
`ifdef OPFETCH_BYPASS_EN
      n_cmp++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL byp_id_ready: got %0b expected 1", bus.id_ready_o); end
      tick();
      n_cmp++; if (bus.ex_valid_o !== 1'b1 || bus.ex_op_a_o !== 32'h12) begin n_err++; $display("FAIL byp_op_a: got v=%0b %h expected v=1 12", bus.ex_valid_o, bus.ex_op_a_o); end
      n_cmp++; if (bus.ex_op_b_o !== 32'h0) begin n_err++; $display("FAIL byp_op_b_x0: got %h expected 0", bus.ex_op_b_o); end
`else
      n_cmp++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL nobyp_id_ready: got %0b expected 0", bus.id_ready_o); end
      tick();
      exp_stall = exp_stall + 1;
      n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL nobyp_stalled: got %0b expected 0", bus.ex_valid_o); end
      n_cmp++; if (bus.stall_cnt_o !== 16'(exp_stall)) begin n_err++; $display("FAIL nobyp_stall_cnt: got %0d expected %0d", bus.stall_cnt_o, exp_stall); end
      bus.wb_valid_i = 1'b0;
      bus.rdata_a_i  = 32'h12;
      #1;
      n_cmp++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL nobyp_ready_after: got %0b expected 1", bus.id_ready_o); end
      tick();
      n_cmp++; if (bus.ex_valid_o !== 1'b1 || bus.ex_op_a_o !== 32'h12) begin n_err++; $display("FAIL nobyp_op_a: got v=%0b %h expected v=1 12", bus.ex_valid_o, bus.ex_op_a_o); end
      n_cmp++; if (bus.ex_op_b_o !== 32'h0) begin n_err++; $display("FAIL nobyp_op_b_x0: got %h expected 0", bus.ex_op_b_o); end
`endif
      n_cmp++; if (dut.busy[3] !== 1'b0 || dut.busy[6] !== 1'b1) begin n_err++; $display("FAIL byp_busy: got b3=%0b b6=%0b expected 0/1", dut.busy[3], dut.busy[6]); end
      n_cmp++; if (bus.stall_cnt_o !== 16'(exp_stall)) begin n_err++; $display("FAIL byp_stall_total: got %0d expected %0d", bus.stall_cnt_o, exp_stall); end
      idle();
      bus.wb_valid_i = 1'b1;
      bus.wb_addr_i  = 5'd6;
      tick();
      bus.wb_valid_i = 1'b0;
      n_cmp++; if (dut.busy !== 32'h0) begin n_err++; $display("FAIL byp_busy_clear: got %h expected 0", dut.busy); end
   endtask

   task automatic test_backpressure();
      idle();
      bus.ex_ready_i = 1'b0;
      present(5'd7, 5'd8, 5'd9, 1'b1, 32'h11, 32'h22);
      tick();
      present(5'd10, 5'd11, 5'd12, 1'b1, 32'h33, 32'h44);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_id_ready[%0d]: got %0b expected 0", i, bus.id_ready_o); end
         tick();
         n_cmp++; if (bus.ex_valid_o !== 1'b1 || bus.ex_op_a_o !== 32'h11 || bus.ex_op_b_o !== 32'h22 || bus.ex_rd_o !== 5'd9) begin
            n_err++; $display("FAIL bp_hold[%0d]: got v=%0b %h/%h rd=%0d expected v=1 11/22 rd=9", i, bus.ex_valid_o, bus.ex_op_a_o, bus.ex_op_b_o, bus.ex_rd_o);
         end
      end
      n_cmp++; if (bus.stall_cnt_o !== 16'(exp_stall)) begin n_err++; $display("FAIL bp_stall_cnt: got %0d expected %0d", bus.stall_cnt_o, exp_stall); end
      bus.ex_ready_i = 1'b1;
      #1;
      n_cmp++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_accept_ready: got %0b expected 1", bus.id_ready_o); end
      tick();
      n_cmp++; if (bus.ex_valid_o !== 1'b1 || bus.ex_op_a_o !== 32'h33 || bus.ex_op_b_o !== 32'h44 || bus.ex_rd_o !== 5'd12) begin
         n_err++; $display("FAIL bp_accept: got v=%0b %h/%h rd=%0d expected v=1 33/44 rd=12", bus.ex_valid_o, bus.ex_op_a_o, bus.ex_op_b_o, bus.ex_rd_o);
      end
      idle();
      bus.wb_valid_i = 1'b1;
      bus.wb_addr_i  = 5'd9;
      tick();
      bus.wb_addr_i  = 5'd12;
      tick();
      bus.wb_valid_i = 1'b0;
      n_cmp++; if (dut.busy !== 32'h0) begin n_err++; $display("FAIL bp_busy_clear: got %h expected 0", dut.busy); end
   endtask

   task automatic test_rd_zero();
      idle();
      present(5'd0, 5'd5, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h55);
      tick();
      bus.id_valid_i = 1'b0;
      n_cmp++; if (bus.ex_valid_o !== 1'b1 || bus.ex_op_a_o !== 32'h0 || bus.ex_op_b_o !== 32'h55) begin
         n_err++; $display("FAIL x0_ops: got v=%0b %h/%h expected v=1 0/55", bus.ex_valid_o, bus.ex_op_a_o, bus.ex_op_b_o);
      end
      n_cmp++; if (bus.ex_rd_we_o !== 1'b0) begin n_err++; $display("FAIL x0_rd_we: got %0b expected 0", bus.ex_rd_we_o); end
      n_cmp++; if (dut.busy !== 32'h0) begin n_err++; $display("FAIL x0_busy: got %h expected 0", dut.busy); end
      tick();
   endtask

   task automatic test_flush();
      idle();
      bus.ex_ready_i = 1'b0;
      present(5'd1, 5'd2, 5'd4, 1'b1, 32'hA, 32'hB);
      tick();
      n_cmp++; if (bus.ex_valid_o !== 1'b1 || dut.busy[4] !== 1'b1) begin n_err++; $display("FAIL flush_pre: got v=%0b b4=%0b expected 1/1", bus.ex_valid_o, dut.busy[4]); end
      present(5'd1, 5'd2, 5'd13, 1'b1, 32'hC, 32'hD);
      bus.flush_i = 1'b1;
      #1;
      n_cmp++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_id_ready: got %0b expected 0", bus.id_ready_o); end
      tick();
      bus.flush_i = 1'b0;
      n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_ex_valid: got %0b expected 0", bus.ex_valid_o); end
      n_cmp++; if (dut.busy[4] !== 1'b0 || dut.busy[13] !== 1'b0) begin n_err++; $display("FAIL flush_busy: got b4=%0b b13=%0b expected 0/0", dut.busy[4], dut.busy[13]); end
      bus.ex_ready_i = 1'b1;
      present(5'd1, 5'd2, 5'd5, 1'b1, 32'hE, 32'hF);
      bus.wb_valid_i = 1'b1;
      bus.wb_addr_i  = 5'd5;
      tick();
      bus.wb_valid_i = 1'b0;
      n_cmp++; if (bus.ex_valid_o !== 1'b1 || dut.busy[5] !== 1'b1) begin n_err++; $display("FAIL set_wins: got v=%0b b5=%0b expected 1/1", bus.ex_valid_o, dut.busy[5]); end
   endtask

   task automatic test_hazard_count();
      present(5'd5, 5'd0, 5'd5, 1'b1, 32'h1, 32'h0);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL haz_id_ready[%0d]: got %0b expected 0", i, bus.id_ready_o); end
         tick();
         exp_stall = exp_stall + 1;
      end
      n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL haz_ex_valid: got %0b expected 0", bus.ex_valid_o); end
      n_cmp++; if (bus.stall_cnt_o !== 16'(exp_stall)) begin n_err++; $display("FAIL haz_stall_cnt: got %0d expected %0d", bus.stall_cnt_o, exp_stall); end
      bus.rs1_i = 5'd0;
      bus.rd_i  = 5'd0;
      bus.id_valid_i = 1'b0;
      present(5'd0, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0);
      #1;
      n_cmp++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL waw_id_ready: got %0b expected 0", bus.id_ready_o); end
      tick();
      exp_stall = exp_stall + 1;
      n_cmp++; if (bus.stall_cnt_o !== 16'(exp_stall)) begin n_err++; $display("FAIL waw_stall_cnt: got %0d expected %0d", bus.stall_cnt_o, exp_stall); end
   endtask

   task automatic test_reset_midhandshake();
      idle();
      bus.ex_ready_i = 1'b0;
      present(5'd1, 5'd2, 5'd7, 1'b1, 32'h77, 32'h88);
      tick();
      bus.id_valid_i = 1'b0;
      n_cmp++; if (bus.ex_valid_o !== 1'b1) begin n_err++; $display("FAIL mid_pre: got %0b expected 1", bus.ex_valid_o); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.ex_valid_o !== 1'b0 || bus.ex_op_a_o !== 32'h0 || bus.ex_rd_o !== 5'd0) begin
         n_err++; $display("FAIL mid_async: got v=%0b %h rd=%0d expected 0 0 0", bus.ex_valid_o, bus.ex_op_a_o, bus.ex_rd_o);
      end
      n_cmp++; if (dut.busy !== 32'h0 || bus.stall_cnt_o !== 16'h0) begin n_err++; $display("FAIL mid_clear: got busy=%h cnt=%0d expected 0/0", dut.busy, bus.stall_cnt_o); end
      tick();
      rst_n = 1'b1;
      bus.ex_ready_i = 1'b1;
      present(5'd1, 5'd0, 5'd8, 1'b1, 32'hAB, 32'h0);
      #1;
      n_cmp++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %0b expected 1", bus.id_ready_o); end
      tick();
      n_cmp++; if (bus.ex_valid_o !== 1'b1 || bus.ex_op_a_o !== 32'hAB || bus.ex_rd_o !== 5'd8) begin
         n_err++; $display("FAIL post_rst_issue: got v=%0b %h rd=%0d expected 1 ab 8", bus.ex_valid_o, bus.ex_op_a_o, bus.ex_rd_o);
      end
      idle();
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      exp_stall = 0;
      test_reset();
      test_basic_issue();
      test_bypass();
      test_backpressure();
      test_rd_zero();
      test_flush();
      test_hazard_count();
      test_reset_midhandshake();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
